// File: rtl/ram_dump.sv
// ram_dump: streams count words from a RAM starting at base_addr,
// through a 2-entry FIFO onto a valid/ready output.
// Ports: clk, rst_n (async, active low); start/base_addr/count request;
// ram_raddr/ram_rdata RAM read port; out_data/out_valid/out_ready/out_last
// stream; busy, done status. With `define RAM_DUMP_CHECKSUM_EN an extra
// output checksum carries the running sum of words sent in this dump.
module ram_dump #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef RAM_DUMP_CHECKSUM_EN
  ,output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } state_t;

  localparam logic [ADDR_W:0]   C_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W:0]   r_left;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_nxt;
  logic              r_p1;
  logic              r_p1_last;
  logic [DATA_W:0]   r_d0;
  logic [DATA_W:0]   r_d1;
  logic [1:0]        r_cnt;
  logic              r_busy;
  logic              r_done;

  logic              w_pop;
  logic              w_push;
  logic [DATA_W:0]   w_in;
  logic [1:0]        w_occ;
  logic [1:0]        w_nxt_cnt;
  logic              w_issue;

  // A read issued last edge lands on ram_rdata now and is pushed.
  assign w_pop     = (r_cnt != 2'd0) && out_ready;
  assign w_push    = r_p1;
  assign w_in      = {r_p1_last, ram_rdata};
  assign w_nxt_cnt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  // Slots committed after this edge if no new read: FIFO words plus
  // the word in flight, less the one leaving now.
  assign w_occ     = r_cnt + {1'b0, r_p1} - {1'b0, w_pop};
  assign w_issue   = (r_state == READ) && (w_occ < 2'd2);

  assign ram_raddr = r_addr;
  assign out_data  = r_d0[DATA_W-1:0];
  assign out_valid = (r_cnt != 2'd0);
  assign out_last  = (r_cnt != 2'd0) && r_d0[DATA_W];
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_left    <= '0;
      r_addr    <= '0;
      r_nxt     <= '0;
      r_p1      <= 1'b0;
      r_p1_last <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_p1      <= 1'b0;
      r_p1_last <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            if (count == '0) begin
              r_state <= FINISH;
            end else begin
              // First read goes out on the accepting edge.
              r_addr    <= base_addr;
              r_nxt     <= base_addr + A_ONE;
              r_p1      <= 1'b1;
              r_p1_last <= (count == C_ONE);
              r_left    <= count - C_ONE;
              r_state   <= (count == C_ONE) ? DRAIN : READ;
            end
          end
        end
        READ: begin
          if (w_issue) begin
            r_addr    <= r_nxt;
            r_nxt     <= r_nxt + A_ONE;
            r_p1      <= 1'b1;
            r_p1_last <= (r_left == C_ONE);
            r_left    <= r_left - C_ONE;
            if (r_left == C_ONE) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_nxt_cnt == 2'd0) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
          end
        end
        FINISH: begin
          // Empty dumps arrive here with done low and pulse on exit;
          // normal dumps already pulsed on entry.
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= ~r_done;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Shift FIFO: head in r_d0 so out_data holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_d0 <= w_in;
          else               r_d1 <= w_in;
        end
        2'b01: r_d0 <= r_d1;
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_d0 <= w_in;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= w_in;
          end
        end
        default: ;
      endcase
      r_cnt <= w_nxt_cnt;
    end
  end

`ifdef RAM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;

  assign checksum = r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (r_state == IDLE && start) begin
      r_sum <= '0;
    end else if (w_pop) begin
      r_sum <= r_sum + r_d0[DATA_W-1:0];
    end
  end
`endif

endmodule

// File: doc/ram_dump.md
RAM_DUMP -- requirements
Module: ram_dump

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM word width.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W, first RAM address; captured with start.
REQ-007 SHALL have port count, input, ADDR_W+1, number of words (0..2^ADDR_W); captured with start.
REQ-008 SHALL have port ram_raddr, output, ADDR_W, RAM read address.
REQ-009 SHALL have port ram_rdata, input, DATA_W, RAM read data, valid exactly one cycle after the edge that presents ram_raddr.
REQ-010 SHALL have port out_data, output, DATA_W, streamed word.
REQ-011 SHALL have port out_valid, output, 1, out_data valid.
REQ-012 SHALL have port out_ready, input, 1, sink accepts; transfer when out_valid && out_ready.
REQ-013 SHALL have port out_last, output, 1, high with the final word of a dump.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse after the last word transfers.

Function
REQ-016 SHALL implement states IDLE, READ, DRAIN, FINISH.
REQ-017 IDLE -> READ on start with count>0; start with count==0 SHALL go IDLE -> FINISH (done pulse, no words).
REQ-018 READ SHALL issue one read per cycle while (buffered + in-flight) < 2, address base_addr+i modulo 2^ADDR_W (wrap 63 -> 0).
REQ-019 Returned words SHALL enter a 2-entry FIFO; out_valid = FIFO non-empty; out_data = FIFO head.
REQ-020 READ -> DRAIN after the count-th read issues; DRAIN -> FINISH when FIFO empty and nothing in flight; FINISH -> IDLE after one cycle with done=1.
REQ-021 With out_ready held high, first out_valid SHALL be 2 cycles after start and throughput SHALL be 1 word/cycle.
REQ-022 out_data/out_valid/out_last SHALL stay stable while out_valid && !out_ready.
REQ-023 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; no word lost or duplicated.
REQ-024 Words SHALL be emitted in address order, exactly count words per dump.
REQ-025 start while busy SHALL be ignored.
REQ-026 ram_raddr SHALL hold its last value when no read is issued.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, empty FIFO, zero in-flight count.
REQ-028 Reset values: ram_raddr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0.
REQ-029 Reset mid-dump SHALL abort without done pulse; next start after release SHALL behave as from power-up.

Configuration
REQ-030 Macro RAM_DUMP_CHECKSUM_EN SHALL, when defined, add output checksum (DATA_W): modulo-2^DATA_W sum of all words transferred in the current dump, cleared on accepted start, stable from done pulse until next accepted start, 0 at reset.
REQ-031 Without RAM_DUMP_CHECKSUM_EN the checksum port and adder SHALL not exist; all other behaviour identical.

Verification
REQ-032 RAM[i]=i+100, base=0, count=4, out_ready=1 -> out_data 100,101,102,103 on consecutive cycles, first at start+2, out_last with 103, done next cycle.
REQ-033 base=62, count=4 -> addresses 62,63,0,1 read; words RAM[62],RAM[63],RAM[0],RAM[1].
REQ-034 count=8, out_ready toggling 1-0-1-0 -> 8 words in order, none dropped or repeated, data stable during stalls.
REQ-035 count=0 -> no out_valid, done pulse 2 cycles after start, busy high for 1 cycle.
REQ-036 rst_n low after 3rd word of count=10 -> all outputs 0 asynchronously, no done; new start base=5,count=2 -> RAM[5],RAM[6].
REQ-037 With RAM_DUMP_CHECKSUM_EN, RAM[0..3]=1,2,3,0xFFFFFFFF, count=4 -> checksum=0x00000005 at done.
